// File: rtl/reg_file.sv
// Integer register file for the RV64 single-cycle core: two combinational
// read ports, one synchronous write port, hardwired x0, optional bypass.
module reg_file #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_wdata,
    input  logic            reg_write,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    localparam bit BYP_EN = (BYPASS != 0);

    // Address space must exactly cover the register array.
    generate
        if ((2 ** AW) != NREG) begin : g_bad_cfg
            $error("reg_file: 2**AW must equal NREG");
        end
    endgenerate

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] wr_en;
    logic            byp1;
    logic            byp2;

    // One-hot write decode; x0 is never selected.
    always_comb begin
        wr_en = '0;
        if (reg_write && (rd_addr != '0)) begin
            wr_en[rd_addr] = 1'b1;
        end
    end

    // Storage: async clear, per-register write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= rd_wdata;
                end
            end
        end
    end

    // Bypass is suppressed during reset so reads stay zero while rst_n is low.
    always_comb begin
        byp1 = BYP_EN && rst_n && reg_write && (rs1_addr == rd_addr);
        byp2 = BYP_EN && rst_n && reg_write && (rs2_addr == rd_addr);
    end

    always_comb begin
        rs1_data = '0;
        if (rst_n && (rs1_addr != '0)) begin
            rs1_data = byp1 ? rd_wdata : regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rst_n && (rs2_addr != '0)) begin
            rs2_data = byp2 ? rd_wdata : regs[rs2_addr];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, reset corner
// sequences and randomized traffic against an array-based reference model.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [63:0] rd_wdata;
    logic        reg_write;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] rs1_data_nb;
    logic [63:0] rs2_data_nb;

    int n_tests;
    int n_fail;

    logic [63:0] model [32];

    reg_file #(.XLEN(64), .NREG(32), .AW(5), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .rd_wdata(rd_wdata), .reg_write(reg_write),
        .rs1_data(rs1_data), .rs2_data(rs2_data)
    );

    reg_file #(.XLEN(64), .NREG(32), .AW(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .rd_wdata(rd_wdata), .reg_write(reg_write),
        .rs1_data(rs1_data_nb), .rs2_data(rs2_data_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] wd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] e1;
        logic [63:0] e2;
        logic [63:0] n1;
        logic [63:0] n2;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural read rule, evaluated on the current bench inputs.
    function automatic logic [63:0] ref_read(input bit byp, input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 64'h0;
        if (byp && reg_write && a == rd_addr) return rd_wdata;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
    endtask

    // Clock edge plus the architectural effect of a write.
    task automatic do_edge();
        @(posedge clk);
        if (rst_n && reg_write && rd_addr != 5'd0) model[rd_addr] = rd_wdata;
        #1;
    endtask

    task automatic set_in(input logic we, input logic [4:0] rd, input logic [63:0] wd,
                          input logic [4:0] a1, input logic [4:0] a2);
        reg_write = we;
        rd_addr   = rd;
        rd_wdata  = wd;
        rs1_addr  = a1;
        rs2_addr  = a2;
    endtask

    task automatic check_model(input string tag);
        check({tag, " rs1 byp"}, rs1_data,    ref_read(1'b1, rs1_addr));
        check({tag, " rs2 byp"}, rs2_data,    ref_read(1'b1, rs2_addr));
        check({tag, " rs1 nobyp"}, rs1_data_nb, ref_read(1'b0, rs1_addr));
        check({tag, " rs2 nobyp"}, rs2_data_nb, ref_read(1'b0, rs2_addr));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_model();
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);

        // Directed vectors from an empty file: {we, rd, wd, rs1, rs2, byp1, byp2, nobyp1, nobyp2}
        vecs[0] = '{1'b1, 5'd7,  64'hF,                 5'd7,  5'd8,  64'hF,    64'h0,    64'h0,    64'h0};
        vecs[1] = '{1'b1, 5'd8,  64'h3,                 5'd7,  5'd8,  64'hF,    64'h3,    64'hF,    64'h0};
        vecs[2] = '{1'b0, 5'd0,  64'h0,                 5'd7,  5'd8,  64'hF,    64'h3,    64'hF,    64'h3};
        vecs[3] = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0,  64'h0,    64'h0,    64'h0,    64'h0};
        vecs[4] = '{1'b0, 5'd0,  64'h0,                 5'd0,  5'd7,  64'h0,    64'hF,    64'h0,    64'hF};
        vecs[5] = '{1'b1, 5'd9,  64'h1,                 5'd9,  5'd0,  64'h1,    64'h0,    64'h0,    64'h0};
        vecs[6] = '{1'b1, 5'd9,  64'hABCD,              5'd9,  5'd9,  64'hABCD, 64'hABCD, 64'h1,    64'h1};
        vecs[7] = '{1'b0, 5'd9,  64'h0,                 5'd9,  5'd9,  64'hABCD, 64'hABCD, 64'hABCD, 64'hABCD};
        vecs[8] = '{1'b0, 5'd12, 64'h55,                5'd12, 5'd12, 64'h0,    64'h0,    64'h0,    64'h0};
        vecs[9] = '{1'b0, 5'd0,  64'h0,                 5'd12, 5'd9,  64'h0,    64'hABCD, 64'h0,    64'hABCD};

        // Reset state: nothing readable while held in reset
        repeat (2) @(posedge clk);
        #1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd31;
        #1;
        check("reset rs1", rs1_data, 64'h0);
        check("reset rs2", rs2_data, 64'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven directed vectors
        for (int v = 0; v < 10; v++) begin
            set_in(vecs[v].we, vecs[v].rd, vecs[v].wd, vecs[v].rs1, vecs[v].rs2);
            #1;
            check($sformatf("vec%0d rs1 byp", v),   rs1_data,    vecs[v].e1);
            check($sformatf("vec%0d rs2 byp", v),   rs2_data,    vecs[v].e2);
            check($sformatf("vec%0d rs1 nobyp", v), rs1_data_nb, vecs[v].n1);
            check($sformatf("vec%0d rs2 nobyp", v), rs2_data_nb, vecs[v].n2);
            if (v == 2) check("alu add x7+x8", rs1_data + rs2_data, 64'h12);
            do_edge();
        end

        // x0 after an attempted write still reads zero
        set_in(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        #1;
        check("x0 after write", rs1_data, 64'h0);

        // Mid-cycle reset clears a preloaded register before the next edge
        set_in(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd5, 5'd5);
        do_edge();
        set_in(1'b0, 5'd0, 64'h0, 5'd5, 5'd9);
        #1;
        check("x5 preload", rs1_data, 64'hDEAD_BEEF_0000_0001);
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        check("x5 async clear", rs1_data, 64'h0);
        check("x9 async clear", rs2_data_nb, 64'h0);

        // Writes during reset are dropped and never bypassed
        set_in(1'b1, 5'd3, 64'h77, 5'd3, 5'd3);
        #1;
        check("rst write byp rs1", rs1_data, 64'h0);
        check("rst write byp rs2", rs2_data, 64'h0);
        repeat (2) do_edge();
        set_in(1'b0, 5'd0, 64'h0, 5'd3, 5'd3);
        #2;
        rst_n = 1'b1;
        #1;
        check("x3 after rst write", rs1_data, 64'h0);
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            check($sformatf("post-reset x%0d p1", a), rs1_data, 64'h0);
            check($sformatf("post-reset x%0d p2", 31 - a), rs2_data_nb, 64'h0);
        end
        do_edge();

        // Randomized traffic against the reference model
        for (int it = 0; it < 400; it++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            set_in(1'($urandom_range(0, 3) != 0), rd, {$urandom, $urandom},
                   ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 31)));
            #1;
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                clear_model();
                #1;
                check_model($sformatf("rnd%0d in reset", it));
                do_edge();
                #2;
                rst_n = 1'b1;
                #1;
            end
            check_model($sformatf("rnd%0d", it));
            do_edge();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
